// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch stage's three handshake groups so that the fetch unit and
//   its environment connect through a single port.
//   Instruction-memory read port : imem_req/imem_addr (out), imem_ready,
//                                  imem_rvalid, imem_rdata (in)
//   Decoder instruction port     : instr_valid/instr/instr_pc (out), instr_ready (in)
//   Branch redirect              : redirect, redirect_pc (in)
//   Directions above are as seen by the fetch unit (master modport); the slave
//   modport is the memory/decoder/branch side.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the 16-bit CPU. Holds the PC, issues word reads
//   to a variable-latency instruction memory (in-order responses), buffers the
//   returned words in a BUF_DEPTH-entry FIFO and hands them to the decoder with
//   a valid/ready handshake. A branch redirect flushes the FIFO and discards
//   every read still in flight.
// Ports
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   io_bus  : fetch_unit_if.master (imem read port, decoder port, redirect)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_BOOT  | one idle cycle after reset, no requests, redirect ignored
//   ST_RUN   | normal fetching, requests issued while there is room
//   ST_FLUSH | waiting for discarded reads to drain, no requests
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       INSTR_W   = 16,
    parameter int unsigned       BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master io_bus
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_buf_instr [BUF_DEPTH];
    logic [ADDR_W-1:0]  r_buf_pc    [BUF_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_drop;

    logic               w_redirect;
    logic               w_pop;
    logic               w_req;
    logic               w_accept;
    logic               w_resp;
    logic               w_push;
    logic               w_discard;
    logic [CNT_W:0]     w_occupancy;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [ADDR_W-1:0]  w_resp_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_redirect = io_bus.redirect && (r_state != ST_BOOT);
    assign w_pop      = (r_count != '0) && io_bus.instr_ready;
    assign w_resp     = io_bus.imem_rvalid;

    // Room check counts the slot freed by a same-cycle pop so that a 1-cycle
    // memory sustains one instruction per cycle with only two entries.
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, r_count}
                       - {{CNT_W{1'b0}}, w_pop};

    assign w_accept  = w_req && io_bus.imem_ready;
    // A redirect-cycle response belongs to the old stream, so it never pushes.
    assign w_push    = w_resp && (r_drop == '0) && (r_state == ST_RUN) && !w_redirect;
    assign w_discard = w_resp && (r_drop != '0);

    assign w_outstanding_nxt = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_resp);

    // Requests in RUN are consecutive and responses are in order, so the
    // oldest in-flight read is always at pc - outstanding; no tag storage needed.
    assign w_resp_pc = r_pc - ADDR_W'(r_outstanding);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_FLUSH: begin
                if (r_state == ST_RUN && !w_redirect) begin
                    w_req = (w_occupancy < (CNT_W + 1)'(BUF_DEPTH));
                end
                if (w_redirect) begin
                    w_state_nxt = (r_outstanding != '0) ? ST_FLUSH : ST_RUN;
                end else if (r_state == ST_FLUSH && r_outstanding == '0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            if (w_redirect) begin
                r_pc   <= io_bus.redirect_pc;
                r_drop <= w_outstanding_nxt;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
                if (w_discard) begin
                    r_drop <= r_drop - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
            end
        end else if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_buf_instr[r_wr_ptr] <= io_bus.imem_rdata;
                r_buf_pc[r_wr_ptr]    <= w_resp_pc;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign io_bus.imem_req    = w_req;
    assign io_bus.imem_addr   = r_pc;
    assign io_bus.instr_valid = (r_count != '0);
    assign io_bus.instr       = r_buf_instr[r_rd_ptr];
    assign io_bus.instr_pc    = r_buf_pc[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 16;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mem_req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .BUF_DEPTH(2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          n_acc;
    int          n_pop;
    int          first_acc;
    int          first_pop;
    int          tb_drop;
    int          mem_lat_min;
    int          mem_lat_max;
    bit          mem_rand;
    logic [15:0] exp_req_addr;
    logic [15:0] exp_q [$];
    mem_req_t    mem_q [$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [15:0] start);
        logic [15:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(a);
            a = a + 16'd1;
        end
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        mem_q.delete();
        tb_drop     = 0;
        mem_rand    = 1'b0;
        mem_lat_min = 1;
        mem_lat_max = 1;
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        cyc          = 0;
        n_acc        = 0;
        n_pop        = 0;
        first_acc    = -1;
        first_pop    = -1;
        exp_req_addr = 16'h0000;
        push_stream(16'h0000);
        #1;
        check_val("boot_no_req", 32'(bus.imem_req), 32'd0);
    endtask

    // One clock cycle: drive inputs at the falling edge, sample 1 ns later,
    // and let the rising edge commit.
    task automatic step(input logic rdy, input logic redir, input logic [15:0] rpc);
        logic     acc;
        logic     hs;
        mem_req_t m;
        @(negedge clk);
        cyc++;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.imem_ready  = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
            if (tb_drop > 0) tb_drop--;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #1;
        acc = bus.imem_req & bus.imem_ready;
        hs  = bus.instr_valid & bus.instr_ready;
        if (acc) begin
            check_val("req_addr", 32'(bus.imem_addr), 32'(exp_req_addr));
            check_val("no_req_during_flush", 32'(tb_drop), 32'd0);
            m.addr = bus.imem_addr;
            m.due  = cyc + int'($urandom_range(mem_lat_min, mem_lat_max));
            mem_q.push_back(m);
            exp_req_addr = exp_req_addr + 16'd1;
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (hs) begin
            check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check_val("instr_pc", 32'(bus.instr_pc), 32'(exp_q[0]));
                check_val("instr", 32'(bus.instr), 32'(mem_word(exp_q[0])));
                void'(exp_q.pop_front());
            end
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
        end else if (bus.instr_valid && exp_q.size() > 0) begin
            check_val("hold_pc", 32'(bus.instr_pc), 32'(exp_q[0]));
            check_val("hold_instr", 32'(bus.instr), 32'(mem_word(exp_q[0])));
        end
        if (redir) begin
            check_val("redir_no_req", 32'(bus.imem_req), 32'd0);
            push_stream(rpc);
            exp_req_addr = rpc;
            tb_drop      = mem_q.size();
        end
    endtask

    int pop_before;

    initial begin
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset values, before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check_val("rst_imem_addr", 32'(bus.imem_addr), 32'h0000);
        check_val("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_val("rst_instr", 32'(bus.instr), 32'd0);
        check_val("rst_instr_pc", 32'(bus.instr_pc), 32'd0);

        // 1) free flow, 1-cycle memory
        do_reset();
        repeat (23) step(1'b1, 1'b0, 16'h0);
        check_val("t1_first_req_cyc", 32'(first_acc), 32'd1);
        check_val("t1_first_instr_cyc", 32'(first_pop), 32'd3);
        check_val("t1_n_req", 32'(n_acc), 32'd23);
        check_val("t1_n_instr", 32'(n_pop), 32'd21);

        // 2) decoder stalled: exactly two requests, head held
        do_reset();
        repeat (8) step(1'b0, 1'b0, 16'h0);
        check_val("t2_n_req", 32'(n_acc), 32'd2);
        check_val("t2_req_stopped", 32'(bus.imem_req), 32'd0);
        check_val("t2_head_valid", 32'(bus.instr_valid), 32'd1);
        check_val("t2_head_pc", 32'(bus.instr_pc), 32'h0000);
        repeat (4) step(1'b1, 1'b0, 16'h0);
        check_val("t2_n_instr", 32'(n_pop), 32'd4);

        // 3) 3-cycle memory, redirect with two reads in flight
        do_reset();
        mem_lat_min = 3;
        mem_lat_max = 3;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) step(1'b1, 1'b0, 16'h0);
        check_val("t3_two_inflight", 32'(mem_q.size()), 32'd2);
        first_acc = -1;
        first_pop = -1;
        step(1'b1, 1'b1, 16'h0040);
        repeat (12) step(1'b1, 1'b0, 16'h0);
        check_val("t3_first_req_cyc", 32'(first_acc), 32'd7);
        check_val("t3_first_instr_cyc", 32'(first_pop), 32'd11);

        // 4) PC wrap after redirect to 0xFFFE
        do_reset();
        repeat (3) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'hFFFE);
        pop_before = n_pop;
        repeat (12) step(1'b1, 1'b0, 16'h0);
        check_val("t4_wrap_progress", 32'(n_pop - pop_before > 4), 32'd1);
        check_val("t4_next_req", 32'(exp_req_addr > 16'h0002 && exp_req_addr < 16'h0010), 32'd1);

        // 5) redirect coincident with response and handshake
        do_reset();
        repeat (5) step(1'b1, 1'b0, 16'h0);
        pop_before = n_pop;
        step(1'b1, 1'b1, 16'h0100);
        check_val("t5_head_consumed", 32'(n_pop - pop_before), 32'd1);
        step(1'b1, 1'b0, 16'h0);
        check_val("t5_flushed", 32'(bus.instr_valid), 32'd0);
        repeat (8) step(1'b1, 1'b0, 16'h0);

        // 6) asynchronous reset mid-operation
        do_reset();
        repeat (6) step(1'b1, 1'b0, 16'h0);
        check_val("t6_pre_req", 32'(bus.imem_req), 32'd1);
        check_val("t6_pre_valid", 32'(bus.instr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_async_valid", 32'(bus.instr_valid), 32'd0);
        check_val("t6_async_req", 32'(bus.imem_req), 32'd0);
        check_val("t6_async_addr", 32'(bus.imem_addr), 32'h0000);
        do_reset();
        repeat (6) step(1'b1, 1'b0, 16'h0);
        check_val("t6_restart_cyc", 32'(first_acc), 32'd1);

        // 7) random memory stalls/latency, decoder stalls and redirects
        do_reset();
        mem_rand    = 1'b1;
        mem_lat_min = 1;
        mem_lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 16'($urandom_range(0, 65535)));
        end
        check_val("t7_progress", 32'(n_pop > 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
